branch_resolve_unit: RTL

Execute-stage consumer of the ALU compare interface. Takes the flag bus from the ALU subtract (rs1 − rs2) plus the operand sign bits, and decides branch/jump outcome under a predict-not-taken policy. On a taken outcome it registers a PC redirect and drives a timed flush of the IF/ID and ID/EX pipeline registers. It also keeps saturating resolution statistics.

---
 rtl/branch_pkg.sv | 26 ++
 rtl/branch_cond.sv | 41 ++++
 rtl/branch_resolve_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution logic.
// Holds ex_kind and funct3 codes, ALU flag bit positions and the FSM state type.
package branch_pkg;

    // Values of ex_kind
    localparam logic [1:0] KIND_BR   = 2'b00;
    localparam logic [1:0] KIND_JAL  = 2'b01;
    localparam logic [1:0] KIND_JALR = 2'b10;
    localparam logic [1:0] KIND_NONE = 2'b11;

    // Branch conditions (funct3); 010 and 011 are illegal
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Bit positions in the ALU flag bus
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator.
// Inputs : flag[2:0] (zero, result MSB, carry/no-borrow of rs1-rs2), op1_msb, op2_msb, funct3.
// Outputs: taken (condition true), illegal (funct3 010/011).
// Kept separate so an early-branch ID stage can reuse it.
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] flag,
    input  logic       op1_msb,
    input  logic       op2_msb,
    input  logic [2:0] funct3,
    output logic       taken,
    output logic       illegal
);

    logic ovf;
    logic eq;
    logic lt;
    logic ltu;

    // Signed overflow of the subtract: operands differ in sign and result sign differs from rs1
    assign ovf = (op1_msb ^ op2_msb) & (op1_msb ^ flag[FLAG_N]);
    assign lt  = flag[FLAG_N] ^ ovf;
    assign ltu = ~flag[FLAG_C];
    assign eq  = flag[FLAG_Z];

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = ~eq;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution under predict-not-taken.
// Inputs : clk, rst_n (sync, active-low), ex_valid, ex_stall, ex_kind, ex_funct3, ex_pc,
//          ex_imm, ex_rs1, alu_flag, op1_msb, op2_msb.
// Outputs: redirect_valid/redirect_pc/target_misaligned (registered redirect), link_pc,
//          flush_ifid/flush_idex (timed squash), illegal_branch, cnt_resolved/cnt_taken
//          (saturating statistics).
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic [1:0]       ex_kind,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [3:0]       alu_flag,
    input  logic             op1_msb,
    input  logic             op2_msb,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             target_misaligned,
    output logic [XLEN-1:0]  link_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             illegal_branch,
    output logic [CNT_W-1:0] cnt_resolved,
    output logic [CNT_W-1:0] cnt_taken
);

    localparam int unsigned FcW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [FcW-1:0] FcLoad = FcW'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e         state_q, state_d;
    logic [FcW-1:0] fcnt_q, fcnt_d;

    logic            cond_taken;
    logic            cond_illegal;
    logic            is_br;
    logic            is_jump;
    logic            accept;
    logic            taken;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] target;
    logic            unused_flag;

    assign unused_flag = alu_flag[3];

    branch_cond u_cond (
        .flag    (alu_flag[2:0]),
        .op1_msb (op1_msb),
        .op2_msb (op2_msb),
        .funct3  (ex_funct3),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    assign is_br   = (ex_kind == KIND_BR);
    assign is_jump = (ex_kind == KIND_JAL) || (ex_kind == KIND_JALR);
    assign accept  = ex_valid && !ex_stall && (state_q == StIdle) && (ex_kind != KIND_NONE);
    assign taken   = is_jump || (is_br && cond_taken);

    // Sums wrap modulo 2^XLEN; JALR clears bit 0
    assign base   = (ex_kind == KIND_JALR) ? ex_rs1 : ex_pc;
    assign sum    = base + ex_imm;
    assign target = (ex_kind == KIND_JALR) ? {sum[XLEN-1:1], 1'b0} : sum;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept && taken) begin
                    state_d = StFlush;
                    fcnt_d  = FcLoad;
                end
            end
            StFlush: begin
                // Counter freezes while stalled, so the flush window stretches
                if (!ex_stall) begin
                    if (fcnt_q == FcW'(1)) begin
                        state_d = StIdle;
                    end else begin
                        fcnt_d = fcnt_q - FcW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            fcnt_q            <= '0;
            redirect_valid    <= 1'b0;
            redirect_pc       <= '0;
            target_misaligned <= 1'b0;
            link_pc           <= '0;
            illegal_branch    <= 1'b0;
            cnt_resolved      <= '0;
            cnt_taken         <= '0;
        end else begin
            state_q           <= state_d;
            fcnt_q            <= fcnt_d;
            redirect_valid    <= accept && taken;
            target_misaligned <= accept && taken && target[1];
            illegal_branch    <= accept && is_br && cond_illegal;
            if (accept && taken) begin
                redirect_pc <= target;
            end
            if (accept && is_jump) begin
                link_pc <= ex_pc + XLEN'(4);
            end
            if (accept && (cnt_resolved != CntMax)) begin
                cnt_resolved <= cnt_resolved + CNT_W'(1);
            end
            if (accept && taken && (cnt_taken != CntMax)) begin
                cnt_taken <= cnt_taken + CNT_W'(1);
            end
        end
    end

    assign flush_ifid = (state_q == StFlush);
    assign flush_idex = (state_q == StFlush);

endmodule
